hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage core: fetch, decode, ALU, memory, writeback.
- Generates the ALU-stage operand forwarding selects (R_1_solve, R_2_solve).
- Generates per-stage enables and flushes for load-use stalls, taken branches/jumps (PCSrc) and data-memory wait states.
- Keeps its own shadow scoreboard of destination registers in ALU, memory and writeback stages, so it needs only decode-stage fields plus a few status inputs.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/fwd_select.sv | 23 ++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_pkg;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_e;
endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one ALU-stage source operand.
module fwd_select #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_rw,
  input  logic                  i_mem_mr,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_rw,
  output logic [1:0]            o_sel
);
  import hazard_pkg::*;

  // A load in MEM has no data yet; load-use stalling keeps it from being needed.
  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_rw && i_mem_rd != '0 && i_mem_rd == i_src && !i_mem_mr)
      o_sel = FWD_MEM;
    else if (i_wb_rw && i_wb_rd != '0 && i_wb_rd == i_src)
      o_sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stalls, redirect flushes and
// memory-wait freezes, driven from a shadow scoreboard of in-flight destinations.
module hazard_ctrl #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_num,
  input  logic [REG_ADDR_W-1:0] id_rs2_num,
  input  logic [REG_ADDR_W-1:0] id_rd_num,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  PCSrc,
  input  logic                  mem_busy,
  output logic [1:0]            R_1_solve,
  output logic [1:0]            R_2_solve,
  output logic                  fetch_en,
  output logic                  decode_en,
  output logic                  alu_en,
  output logic                  mem_en,
  output logic                  decode_flush,
  output logic                  alu_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  import hazard_pkg::*;

  state_e                r_state, w_state_nxt;
  logic [REG_ADDR_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd, r_mem_rd, r_wb_rd;
  logic                  r_ex_rw, r_ex_mr, r_mem_rw, r_mem_mr, r_wb_rw;
  logic                  w_hold, w_lu, w_redirect, w_stall, w_bubble;
  logic [1:0]            w_sel1, w_sel2;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
    .i_src(r_ex_rs1), .i_mem_rd(r_mem_rd), .i_mem_rw(r_mem_rw), .i_mem_mr(r_mem_mr),
    .i_wb_rd(r_wb_rd), .i_wb_rw(r_wb_rw), .o_sel(w_sel1)
  );
  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
    .i_src(r_ex_rs2), .i_mem_rd(r_mem_rd), .i_mem_rw(r_mem_rw), .i_mem_mr(r_mem_mr),
    .i_wb_rd(r_wb_rd), .i_wb_rw(r_wb_rw), .o_sel(w_sel2)
  );

  // Leaving FREEZE is evaluated as RUN in the same cycle, so both states hold on mem_busy.
  always_comb begin
    w_hold      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        w_hold      = mem_busy;
        w_state_nxt = mem_busy ? FREEZE : RUN;
      end
      FREEZE: begin
        w_hold      = mem_busy;
        w_state_nxt = mem_busy ? FREEZE : RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_lu = id_valid && r_ex_mr && r_ex_rw && r_ex_rd != '0 &&
                (r_ex_rd == id_rs1_num || r_ex_rd == id_rs2_num);
  // A redirect squashes the would-be stalled consumer, so it outranks load-use.
  assign w_redirect = !w_hold && PCSrc;
  assign w_stall    = !w_hold && !PCSrc && w_lu;
  assign w_bubble   = w_redirect || w_stall;

  always_comb begin
    R_1_solve    = w_sel1;
    R_2_solve    = w_sel2;
    fetch_en     = !w_hold && !w_stall;
    decode_en    = !w_hold && !w_stall;
    alu_en       = !w_hold;
    mem_en       = !w_hold;
    decode_flush = w_redirect;
    alu_flush    = w_bubble;
    if (reset) begin
      R_1_solve    = '0;
      R_2_solve    = '0;
      fetch_en     = 1'b1;
      decode_en    = 1'b1;
      alu_en       = 1'b1;
      mem_en       = 1'b1;
      decode_flush = 1'b0;
      alu_flush    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_ex_rs1 <= '0; r_ex_rs2 <= '0; r_ex_rd <= '0; r_ex_rw <= 1'b0; r_ex_mr <= 1'b0;
      r_mem_rd <= '0; r_mem_rw <= 1'b0; r_mem_mr <= 1'b0;
      r_wb_rd  <= '0; r_wb_rw  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_hold) begin
        r_wb_rd  <= r_mem_rd;
        r_wb_rw  <= r_mem_rw;
        r_mem_rd <= r_ex_rd;
        r_mem_rw <= r_ex_rw;
        r_mem_mr <= r_ex_mr;
        if (w_bubble || !id_valid) begin
          r_ex_rs1 <= '0; r_ex_rs2 <= '0; r_ex_rd <= '0; r_ex_rw <= 1'b0; r_ex_mr <= 1'b0;
        end else begin
          r_ex_rs1 <= id_rs1_num;
          r_ex_rs2 <= id_rs2_num;
          r_ex_rd  <= id_rd_num;
          r_ex_rw  <= id_reg_write;
          r_ex_mr  <= id_mem_read;
        end
      end
      if (w_hold || w_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (w_redirect)        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
